// File: rtl/hci_core_r_valid_tracker.sv
// In-order response filter for HCI core channels: remembers whether each granted
// request was a read or a write and forwards r_valid upstream only for reads.
module hci_core_r_valid_tracker #(
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned UW              = 1,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CW              = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            enable_i,
    input  logic            s_req_i,
    output logic            s_gnt_o,
    input  logic [AW-1:0]   s_add_i,
    input  logic            s_we_n_i,
    input  logic [DW-1:0]   s_data_i,
    input  logic [DW/8-1:0] s_be_i,
    input  logic [UW-1:0]   s_user_i,
    output logic [DW-1:0]   s_r_data_o,
    output logic [UW-1:0]   s_r_user_o,
    output logic            s_r_valid_o,
    output logic            m_req_o,
    input  logic            m_gnt_i,
    output logic [AW-1:0]   m_add_o,
    output logic            m_we_n_o,
    output logic [DW-1:0]   m_data_o,
    output logic [DW/8-1:0] m_be_o,
    output logic [UW-1:0]   m_user_o,
    input  logic [DW-1:0]   m_r_data_i,
    input  logic [UW-1:0]   m_r_user_i,
    input  logic            m_r_valid_i,
    output logic [CW-1:0]   outstanding_o,
    output logic            full_o,
    output logic            err_o
);

    localparam int unsigned   PW      = $clog2(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] r_type;
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic                       r_err;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_head_we_n;

    assign m_add_o    = s_add_i;
    assign m_we_n_o   = s_we_n_i;
    assign m_data_o   = s_data_i;
    assign m_be_o     = s_be_i;
    assign m_user_o   = s_user_i;
    assign s_r_data_o = m_r_data_i;
    assign s_r_user_o = m_r_user_i;

    assign outstanding_o = r_count;
    assign full_o        = w_full;
    assign err_o         = r_err;

    // Occupancy flags and handshake gating; the grant path never depends on req.
    always_comb begin
        w_empty     = (r_count == {CW{1'b0}});
        w_full      = (r_count == CNT_MAX);
        m_req_o     = s_req_i & ~w_full;
        s_gnt_o     = m_gnt_i & ~w_full;
        w_push      = s_req_i & s_gnt_o;
        w_pop       = m_r_valid_i & ~w_empty;
        w_head_we_n = r_type[r_rd_ptr];
    end

    // Response filter: with the filter disabled the raw valid passes straight through.
    always_comb begin
        s_r_valid_o = 1'b0;
        if (enable_i) begin
            s_r_valid_o = m_r_valid_i & ~w_empty & w_head_we_n;
        end else begin
            s_r_valid_o = m_r_valid_i;
        end
    end

    // Type FIFO, pointers, occupancy and sticky error; tracking ignores enable_i.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_type   <= {MAX_OUTSTANDING{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_type[r_wr_ptr] <= s_we_n_i;
                r_wr_ptr         <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (m_r_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hci_core_r_valid_tracker.sv
// Scoreboard bench for hci_core_r_valid_tracker: directed scenarios followed by random traffic.
module tb_hci_core_r_valid_tracker;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int UW = 1;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;

    logic            clk_i = 1'b0;
    logic            rst_i, clear_i, enable_i;
    logic            s_req_i, s_gnt_o, s_we_n_i, s_r_valid_o;
    logic [AW-1:0]   s_add_i, m_add_o;
    logic [DW-1:0]   s_data_i, s_r_data_o, m_data_o, m_r_data_i;
    logic [DW/8-1:0] s_be_i, m_be_o;
    logic [UW-1:0]   s_user_i, s_r_user_o, m_user_o, m_r_user_i;
    logic            m_req_o, m_gnt_i, m_we_n_o, m_r_valid_i;
    logic [CW-1:0]   outstanding_o;
    logic            full_o, err_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: the types of in-flight transactions, oldest first.
    bit exp_q[$];
    bit exp_err   = 1'b0;
    bit model_ok  = 1'b0;
    int peak      = 0;

    hci_core_r_valid_tracker #(.AW(AW), .DW(DW), .UW(UW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
        .s_req_i(s_req_i), .s_gnt_o(s_gnt_o), .s_add_i(s_add_i), .s_we_n_i(s_we_n_i),
        .s_data_i(s_data_i), .s_be_i(s_be_i), .s_user_i(s_user_i),
        .s_r_data_o(s_r_data_o), .s_r_user_o(s_r_user_o), .s_r_valid_o(s_r_valid_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_add_o(m_add_o), .m_we_n_o(m_we_n_o),
        .m_data_o(m_data_o), .m_be_o(m_be_o), .m_user_o(m_user_o),
        .m_r_data_i(m_r_data_i), .m_r_user_i(m_r_user_i), .m_r_valid_i(m_r_valid_i),
        .outstanding_o(outstanding_o), .full_o(full_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard update on the active edge, using the inputs held during the cycle.
    always @(posedge clk_i) begin
        int  n;
        bit  full_m;
        n      = exp_q.size();
        full_m = (n == MO);
        if (rst_i || clear_i) begin
            exp_q.delete();
            exp_err  = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (m_r_valid_i && n == 0) exp_err = 1'b1;
            if (m_r_valid_i && n > 0) void'(exp_q.pop_front());
            if (s_req_i && m_gnt_i && !full_m) exp_q.push_back(s_we_n_i);
            if (exp_q.size() > peak) peak = exp_q.size();
        end
    end

    // Monitor: compares every DUT output mid-cycle against the reference.
    always @(negedge clk_i) begin
        int n;
        bit full_m, rv_m;
        if (model_ok) begin
            n      = exp_q.size();
            full_m = (n == MO);
            if (enable_i) rv_m = m_r_valid_i && (n > 0) && exp_q[0];
            else          rv_m = m_r_valid_i;
            chk("s_r_valid", 32'(s_r_valid_o), 32'(rv_m));
            chk("outstanding", 32'(outstanding_o), 32'(n));
            chk("full", 32'(full_o), 32'(full_m));
            chk("err", 32'(err_o), 32'(exp_err));
            chk("m_req", 32'(m_req_o), 32'(s_req_i && !full_m));
            chk("s_gnt", 32'(s_gnt_o), 32'(m_gnt_i && !full_m));
            chk("m_add", m_add_o, s_add_i);
            chk("m_data", m_data_o, s_data_i);
            chk("pass_misc", {22'd0, m_we_n_o, m_be_o, m_user_o, s_r_user_o},
                {22'd0, s_we_n_i, s_be_i, s_user_i, m_r_user_i});
            chk("s_r_data", s_r_data_o, m_r_data_i);
        end
    end

    task automatic step(input bit req, input bit we_n, input bit gnt, input bit rv,
                        input bit en, input bit clr);
        s_req_i     = req;
        s_we_n_i    = we_n;
        m_gnt_i     = gnt;
        m_r_valid_i = rv;
        enable_i    = en;
        clear_i     = clr;
        s_add_i     = $urandom;
        s_data_i    = $urandom;
        s_be_i      = 4'($urandom);
        s_user_i    = 1'($urandom);
        m_r_data_i  = $urandom;
        m_r_user_i  = 1'($urandom);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit pat [4];
        rst_i = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        rst_i = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // T1 read, T2 write filtered and unfiltered.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // T3 W,R,W,R with responses three cycles behind.
        pat = '{1'b0, 1'b1, 1'b0, 1'b1};
        peak = 0;
        for (int i = 0; i < 7; i++)
            step(i < 4, (i < 4) ? pat[i] : 1'b0, i < 4, i >= 3, 1'b1, 1'b0);
        chk("t3_peak", 32'(peak), 32'd3);
        // T4 fill with reads, then one response releases the stall.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_full", 32'(full_o), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        // T5 push and pop together at count 2.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_count", 32'(outstanding_o), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        // T6 spurious response, then clear with three in flight.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t6_err", 32'(err_o), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_clear", {31'd0, err_o}, 32'd0);
        // Random traffic with occasional clears, resets and enable flips.
        for (int i = 0; i < 3000; i++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 99) == 0));
        end
        rst_i = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
